regfile_read_arbiter: RTL and testbench
=======================================

Name: regfile_read_arbiter

Overview:
- Shares the single 64-bit, 32-entry register-file read port (a 32:1 x64 select) between NREQ pipeline requesters: decode Rn, decode Rm, and store-data.
- Arbitration is round-robin, with an optional lock so one requester can hold the port for back-to-back reads (LDP/STP).
- Responses are registered: one cycle of latency.
- Handles the zero register (X31) and same-cycle write-back forwarding, so requesters never see stale data.

Parameters:
- NREQ, 3, number of requesters (2..8).
- WIDTH, 64, data width.
- AW, 5, register address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  request i is presenting a read.
- req_addr  in  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW].
- req_lock  in  NREQ  requester i holds the grant while asserted and granted.
- req_ready  out  NREQ  one-hot grant; a read is accepted when req_valid[i] & req_ready[i].
- mux_sel  out  AW  select driven to the read-port mux.
- mux_data  in  WIDTH  combinational data returned by the mux for mux_sel.
- wr_en  in  1  register-file write this cycle.
- wr_addr  in  AW  write address.
- wr_data  in  WIDTH  write data.
- rsp_valid  out  NREQ  one-hot, registered; response for requester i.
- rsp_data  out  WIDTH  registered read data.

Behaviour:
- Reset (reset_n low, asynchronous):
  - rsp_valid=0, rsp_data=0.
  - Round-robin pointer ptr=0, lock owner cleared.
  - req_ready=0 and mux_sel=0 while reset_n is low.
  - Asserting reset mid-operation drops any in-flight response: no rsp_valid on the cycle after release.
- Grant (combinational, every cycle):
  - If the lock owner L is valid and req_valid[L] is high, grant L.
  - Otherwise grant the first i with req_valid[i] set, scanning from ptr upward and wrapping past NREQ-1 to 0.
  - No valid requesters: req_ready=0, mux_sel holds its last value.
  - At most one req_ready bit is ever set.
  - req_ready does not depend on rsp state; there is no backpressure.
- Address select: mux_sel = req_addr of the granted requester.
- Pointer update on a grant to g: ptr <= (g+1) mod NREQ. ptr is also updated while locked.
- Lock rules:
  - Grant to g with req_lock[g]=1: owner <= g.
  - Owner cleared when it is granted with req_lock=0, or when req_valid[owner]=0.
  - A lock asserted by a non-granted requester has no effect.
- Response (1-cycle latency). A grant to g at cycle t gives, at t+1:
  - rsp_valid = one-hot(g).
  - rsp_data, selected in priority order:
    1. addr==31 -> 0 (XZR; the mux is not trusted for X31).
    2. wr_en & wr_addr==addr & addr!=31 -> wr_data (forward, because the file updates at the same edge).
    3. otherwise mux_data.
  - No grant at t: rsp_valid=0 at t+1, rsp_data holds its previous value.
- Writes to X31 are never forwarded.
- Throughput: one read per cycle total, sustained.

Test Plan:
- Reset/idle: reset_n=0 for 2 cycles with req_valid=3'b111 -> req_ready=0, rsp_valid=0, rsp_data=0. After release with all requests valid, first grant is req 0.
- Round-robin: req_valid=3'b111 held for 6 cycles, addrs 1/2/3, mux model returns 64'h100+addr -> grants 0,1,2,0,1,2. rsp_valid trails by one cycle, data 64'h101, 64'h102, 64'h103 repeating.
- Lock: req 1 granted with req_lock[1]=1 for 3 cycles while req 0 and req 2 are valid -> req 1 granted 3 consecutive cycles. On the cycle req_lock drops, req 1 gets its last grant; req 2 is granted on the following cycle.
- Forwarding: grant addr 7 with wr_en=1, wr_addr=7, wr_data=64'hDEADBEEF_CAFEF00D, mux_data=64'h0 -> next cycle rsp_data=64'hDEADBEEF_CAFEF00D. Same stimulus with wr_addr=8 -> rsp_data=64'h0.
- XZR: grant addr 31 with mux_data=64'hFFFF_FFFF_FFFF_FFFF, and separately with wr_en=1, wr_addr=31, wr_data=64'h5 -> rsp_data=0 in both cases.
- Reset mid-flight: grant req 2 at t, pulse reset_n low between t and t+1 -> rsp_valid=0 at t+1, ptr=0, lock cleared.

Source files
------------

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port between NREQ requesters.
// Supports lock-based back-to-back reads, XZR, and same-cycle write-back forwarding.
module regfile_read_arbiter #(
  parameter int NREQ  = 3,
  parameter int WIDTH = 64,
  parameter int AW    = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ-1:0]      req_lock,
  output logic [NREQ-1:0]      req_ready,
  output logic [AW-1:0]        mux_sel,
  input  logic [WIDTH-1:0]     mux_data,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [WIDTH-1:0]     rsp_data
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW-1:0] XZR = '1;

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic             owner_vld_q, owner_vld_d;
  logic [AW-1:0]    sel_q, sel_d;
  logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic             gnt_any;
  logic [PW-1:0]    gnt_idx;
  logic [PW:0]      scan;
  logic [AW-1:0]    gnt_addr;
  logic [AW-1:0]    addr_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_addr
    assign addr_arr[gi] = req_addr[gi*AW +: AW];
  end

  // Lock owner wins while still requesting; otherwise scan upward from ptr with wrap.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    if (owner_vld_q && req_valid[owner_q]) begin
      gnt_any = 1'b1;
      gnt_idx = owner_q;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        scan = {1'b0, ptr_q} + (PW+1)'(k);
        if (scan >= (PW+1)'(NREQ)) scan = scan - (PW+1)'(NREQ);
        if (!gnt_any && req_valid[scan[PW-1:0]]) begin
          gnt_any = 1'b1;
          gnt_idx = scan[PW-1:0];
        end
      end
    end
  end

  assign gnt_addr = addr_arr[gnt_idx];

  always_comb begin
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    owner_vld_d = 1'b0;
    sel_d       = sel_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (gnt_any) begin
      ptr_d       = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      owner_d     = gnt_idx;
      owner_vld_d = req_lock[gnt_idx];
      sel_d       = gnt_addr;
      rsp_valid_d = {{(NREQ-1){1'b0}}, 1'b1} << gnt_idx;
      // The file is written at the same edge we sample, so a matching write must be bypassed.
      if (gnt_addr == XZR)
        rsp_data_d = '0;
      else if (wr_en && (wr_addr == gnt_addr))
        rsp_data_d = wr_data;
      else
        rsp_data_d = mux_data;
    end
  end

  // Handshake: a read transfers when req_valid[i] & req_ready[i]; no backpressure on responses.
  assign req_ready = (reset_n && gnt_any) ? rsp_valid_d : '0;
  assign mux_sel   = reset_n ? sel_d : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q       <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      sel_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Bench for regfile_read_arbiter: directed scenarios plus randomized traffic
// checked against a rule-level reference model with an expected-data queue.
module tb_regfile_read_arbiter;
  localparam int NREQ = 3, WIDTH = 64, AW = 5;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [2:0]       req_valid, req_lock, req_ready, rsp_valid;
  logic [4:0]       addr_a [3];
  logic [14:0]      req_addr;
  logic [4:0]       mux_sel, wr_addr;
  logic [63:0]      mux_data, wr_data, rsp_data;
  logic             wr_en;
  logic [63:0]      rf [32];
  logic             mux_force;
  logic [63:0]      mux_force_val;

  int n_vec = 0, n_fail = 0;

  // reference model state
  int          m_ptr, m_owner, m_rsp_g;
  logic [4:0]  m_sel;
  logic [63:0] m_last;
  logic [63:0] exp_q [$];

  assign req_addr = {addr_a[2], addr_a[1], addr_a[0]};
  assign mux_data = mux_force ? mux_force_val : rf[mux_sel];

  regfile_read_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_lock(req_lock), .req_ready(req_ready), .mux_sel(mux_sel), .mux_data(mux_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset_n = 1'b0; req_valid = '0; req_lock = '0; wr_en = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  function automatic int model_grant();
    if (m_owner >= 0 && req_valid[m_owner]) return m_owner;
    for (int k = 0; k < NREQ; k++)
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic model_commit(input int g);
    logic [4:0]  a;
    logic [63:0] d;
    if (g >= 0) begin
      a = addr_a[g];
      if (a == 5'd31)                   d = '0;
      else if (wr_en && wr_addr == a)   d = wr_data;
      else if (mux_force)               d = mux_force_val;
      else                              d = rf[a];
      exp_q.push_back(d);
      m_ptr   = (g + 1) % NREQ;
      m_owner = req_lock[g] ? g : -1;
      m_sel   = a;
    end else begin
      m_owner = -1;
    end
    m_rsp_g = g;
  endtask

  task automatic test_reset();
    req_valid = 3'b111; req_lock = '0;
    addr_a[0] = 5'd1; addr_a[1] = 5'd2; addr_a[2] = 5'd3;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_vec++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL rst_ready c%0d got %b want 000", i, req_ready); end
      n_vec++; if (rsp_valid !== 3'b000) begin n_fail++; $display("FAIL rst_rsp_valid c%0d got %b want 000", i, rsp_valid); end
      n_vec++; if (rsp_data !== 64'h0) begin n_fail++; $display("FAIL rst_rsp_data c%0d got %h want 0", i, rsp_data); end
      n_vec++; if (mux_sel !== 5'd0) begin n_fail++; $display("FAIL rst_mux_sel c%0d got %0d want 0", i, mux_sel); end
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    n_vec++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL rst_first_grant got %b want 001", req_ready); end
    n_vec++; if (mux_sel !== 5'd1) begin n_fail++; $display("FAIL rst_first_sel got %0d want 1", mux_sel); end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_r, exp_v;
    logic [4:0]  exp_s;
    logic [63:0] exp_d;
    do_reset();
    mux_force = 1'b0; req_lock = '0; wr_en = 1'b0;
    addr_a[0] = 5'd1; addr_a[1] = 5'd2; addr_a[2] = 5'd3;
    req_valid = 3'b111;
    for (int i = 0; i < 8; i++) begin
      if (i == 6) req_valid = 3'b000;
      @(negedge clk);
      if (i < 6) begin exp_r = 3'b001 << (i % 3); exp_s = 5'((i % 3) + 1); end
      else begin exp_r = 3'b000; exp_s = 5'd3; end
      if (i > 0 && i < 7) begin exp_v = 3'b001 << ((i - 1) % 3); exp_d = 64'h100 + 64'(((i - 1) % 3) + 1); end
      else if (i == 7) begin exp_v = 3'b000; exp_d = 64'h103; end
      else begin exp_v = 3'b000; exp_d = 64'h0; end
      n_vec++; if (req_ready !== exp_r) begin n_fail++; $display("FAIL rr_ready c%0d got %b want %b", i, req_ready, exp_r); end
      n_vec++; if (mux_sel !== exp_s) begin n_fail++; $display("FAIL rr_sel c%0d got %0d want %0d", i, mux_sel, exp_s); end
      n_vec++; if (rsp_valid !== exp_v) begin n_fail++; $display("FAIL rr_rsp_valid c%0d got %b want %b", i, rsp_valid, exp_v); end
      n_vec++; if (rsp_data !== exp_d) begin n_fail++; $display("FAIL rr_rsp_data c%0d got %h want %h", i, rsp_data, exp_d); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lock();
    logic [2:0] exp_r;
    do_reset();
    addr_a[0] = 5'd4; addr_a[1] = 5'd5; addr_a[2] = 5'd6;
    req_valid = 3'b001; req_lock = '0;
    @(negedge clk);
    n_vec++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL lock_pre got %b want 001", req_ready); end
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      req_valid = 3'b111;
      req_lock  = (i < 3) ? 3'b010 : 3'b000;
      @(negedge clk);
      exp_r = (i < 4) ? 3'b010 : 3'b100;
      n_vec++; if (req_ready !== exp_r) begin n_fail++; $display("FAIL lock_grant c%0d got %b want %b", i, req_ready, exp_r); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_forward();
    do_reset();
    mux_force = 1'b1; mux_force_val = 64'h0; req_lock = '0;
    addr_a[0] = 5'd7; req_valid = 3'b001;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'hDEADBEEF_CAFEF00D;
    @(negedge clk);
    n_vec++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL fwd_ready got %b want 001", req_ready); end
    @(posedge clk); #1;
    wr_addr = 5'd8;
    @(negedge clk);
    n_vec++; if (rsp_valid !== 3'b001) begin n_fail++; $display("FAIL fwd_rsp_valid got %b want 001", rsp_valid); end
    n_vec++; if (rsp_data !== 64'hDEADBEEF_CAFEF00D) begin n_fail++; $display("FAIL fwd_hit got %h want deadbeefcafef00d", rsp_data); end
    @(posedge clk); #1;
    req_valid = '0; wr_en = 1'b0;
    @(negedge clk);
    n_vec++; if (rsp_data !== 64'h0) begin n_fail++; $display("FAIL fwd_miss got %h want 0", rsp_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_xzr();
    do_reset();
    mux_force = 1'b1; mux_force_val = 64'hFFFF_FFFF_FFFF_FFFF; req_lock = '0; wr_en = 1'b0;
    addr_a[0] = 5'd5; req_valid = 3'b001;
    @(posedge clk); #1;
    addr_a[0] = 5'd31;
    @(negedge clk);
    n_vec++; if (mux_sel !== 5'd31) begin n_fail++; $display("FAIL xzr_sel got %0d want 31", mux_sel); end
    n_vec++; if (rsp_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL xzr_pre got %h want ffffffffffffffff", rsp_data); end
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'h5;
    @(negedge clk);
    n_vec++; if (rsp_data !== 64'h0) begin n_fail++; $display("FAIL xzr_mux got %h want 0", rsp_data); end
    @(posedge clk); #1;
    req_valid = '0; wr_en = 1'b0;
    @(negedge clk);
    n_vec++; if (rsp_data !== 64'h0) begin n_fail++; $display("FAIL xzr_nofwd got %h want 0", rsp_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    mux_force = 1'b1; mux_force_val = 64'h55; wr_en = 1'b0;
    addr_a[0] = 5'd1; addr_a[1] = 5'd2; addr_a[2] = 5'd9;
    req_valid = 3'b100; req_lock = 3'b100;
    @(negedge clk);
    n_vec++; if (req_ready !== 3'b100) begin n_fail++; $display("FAIL mid_grant got %b want 100", req_ready); end
    @(posedge clk); #1;
    n_vec++; if (rsp_valid !== 3'b100) begin n_fail++; $display("FAIL mid_inflight got %b want 100", rsp_valid); end
    reset_n = 1'b0; #2; reset_n = 1'b1;
    req_valid = 3'b111; req_lock = '0;
    @(negedge clk);
    n_vec++; if (rsp_valid !== 3'b000) begin n_fail++; $display("FAIL mid_rsp_valid got %b want 000", rsp_valid); end
    n_vec++; if (rsp_data !== 64'h0) begin n_fail++; $display("FAIL mid_rsp_data got %h want 0", rsp_data); end
    n_vec++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL mid_ptr_lock got %b want 001", req_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (rsp_valid !== 3'b001 || rsp_data !== 64'h55) begin
      n_fail++; $display("FAIL mid_recover got %b/%h want 001/55", rsp_valid, rsp_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int          g;
    logic [2:0]  exp_r, exp_v;
    logic [4:0]  exp_s;
    do_reset();
    mux_force = 1'b0;
    m_ptr = 0; m_owner = -1; m_rsp_g = -1; m_sel = '0; m_last = '0;
    exp_q.delete();
    for (int a = 0; a < 32; a++) rf[a] = {$urandom, $urandom};
    for (int c = 0; c < 400; c++) begin
      req_valid = 3'($urandom_range(0, 7));
      for (int i = 0; i < 3; i++) begin
        req_lock[i] = ($urandom_range(0, 2) != 0);
        addr_a[i]   = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      end
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = ($urandom_range(0, 1) == 1) ? addr_a[$urandom_range(0, 2)] : 5'($urandom_range(0, 31));
      wr_data = {$urandom, $urandom};
      rf[$urandom_range(0, 31)] = {$urandom, $urandom};
      @(negedge clk);
      exp_v = (m_rsp_g >= 0) ? (3'b001 << m_rsp_g) : 3'b000;
      if (m_rsp_g >= 0 && exp_q.size() > 0) m_last = exp_q.pop_front();
      n_vec++; if (rsp_valid !== exp_v) begin n_fail++; $display("FAIL rnd_rsp_valid c%0d got %b want %b", c, rsp_valid, exp_v); end
      n_vec++; if (rsp_data !== m_last) begin n_fail++; $display("FAIL rnd_rsp_data c%0d got %h want %h", c, rsp_data, m_last); end
      g = model_grant();
      exp_r = (g >= 0) ? (3'b001 << g) : 3'b000;
      exp_s = (g >= 0) ? addr_a[g] : m_sel;
      n_vec++; if (req_ready !== exp_r) begin n_fail++; $display("FAIL rnd_ready c%0d got %b want %b", c, req_ready, exp_r); end
      n_vec++; if (mux_sel !== exp_s) begin n_fail++; $display("FAIL rnd_sel c%0d got %0d want %0d", c, mux_sel, exp_s); end
      model_commit(g);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    req_valid = '0; req_lock = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    mux_force = 1'b0; mux_force_val = '0;
    for (int a = 0; a < 32; a++) rf[a] = 64'h100 + 64'(a);
    for (int i = 0; i < 3; i++) addr_a[i] = '0;
    test_reset();
    test_round_robin();
    test_lock();
    test_forward();
    test_xzr();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
